// File: rtl/data_memory_ws.sv
// Byte-addressed little-endian data memory with a valid/ready request port and
// a fixed number of wait states per access; reports size/alignment/range errors.
module data_memory_ws #(
   parameter int DEPTH_BYTES = 128,
   parameter int ADDR_W      = 32,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy
);
   localparam int              AW       = $clog2(DEPTH_BYTES);
   localparam logic            ZERO_LAT = (LATENCY == 0);
   localparam logic [3:0]      LAT4     = 4'(LATENCY);
   localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH_BYTES);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // End address is formed one bit wider so addresses near the top never wrap into range.
   function automatic logic access_err(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] end_a;
      logic            bad;
      end_a = {1'b0, a} + (ADDR_W+1)'(size_bytes(sz));
      bad   = (end_a > DEPTH_X);
      case (sz)
         2'b00:   bad = bad;
         2'b01:   bad = bad | a[0];
         2'b10:   bad = bad | (a[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] extend(input logic [1:0] sz, input logic uns, input logic [31:0] w);
      case (sz)
         2'b00:   return uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         2'b01:   return uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   logic [7:0]        mem_q [DEPTH_BYTES];
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q, uns_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

   logic              accept_s, commit_s;
   logic              c_write_s, c_uns_s, c_err_s;
   logic [1:0]        c_size_s;
   logic [ADDR_W-1:0] c_addr_s;
   logic [31:0]       c_wdata_s, rd_word_s;
   logic [AW-1:0]     idx0_s, idx1_s, idx2_s, idx3_s;

   assign req_ready = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && reset;
   assign busy      = (state_q != ST_IDLE);
   assign accept_s  = req_valid && req_ready;
   assign commit_s  = reset && (ZERO_LAT ? accept_s : ((state_q == ST_WAIT) && (cnt_q == 4'd1)));

   // With zero wait states the commit happens on the accept edge, so use the live request.
   assign c_write_s = ZERO_LAT ? req_write    : write_q;
   assign c_size_s  = ZERO_LAT ? req_size     : size_q;
   assign c_uns_s   = ZERO_LAT ? req_unsigned : uns_q;
   assign c_addr_s  = ZERO_LAT ? req_addr     : addr_q;
   assign c_wdata_s = ZERO_LAT ? req_wdata    : wdata_q;
   assign c_err_s   = access_err(c_size_s, c_addr_s);

   assign idx0_s    = c_addr_s[AW-1:0];
   assign idx1_s    = idx0_s + AW'(32'd1);
   assign idx2_s    = idx0_s + AW'(32'd2);
   assign idx3_s    = idx0_s + AW'(32'd3);
   assign rd_word_s = {mem_q[idx3_s], mem_q[idx2_s], mem_q[idx1_s], mem_q[idx0_s]};

   // Next-state logic for the IDLE/WAIT/RESP sequencer and the response registers.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      resp_valid_d = commit_s;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept_s) begin
               if (ZERO_LAT) begin
                  state_d = ST_RESP;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT4;
               end
            end else begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d = ST_RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      if (commit_s) begin
         resp_err_d   = c_err_s;
         resp_rdata_d = (c_err_s || c_write_s) ? 32'd0 : extend(c_size_s, c_uns_s, rd_word_s);
      end else begin
         resp_err_d   = resp_err_q;
      end
   end

   // Control and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         if (accept_s) begin
            write_q <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end else begin
            write_q <= write_q;
         end
      end
   end

   // Storage is not reset; only committed, error-free stores modify it.
   always_ff @(posedge clk) begin
      if (commit_s && c_write_s && !c_err_s) begin
         mem_q[idx0_s] <= c_wdata_s[7:0];
         case (c_size_s)
            2'b01: mem_q[idx1_s] <= c_wdata_s[15:8];
            2'b10: begin
               mem_q[idx1_s] <= c_wdata_s[15:8];
               mem_q[idx2_s] <= c_wdata_s[23:16];
               mem_q[idx3_s] <= c_wdata_s[31:24];
            end
            default: mem_q[idx0_s] <= c_wdata_s[7:0];
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: three instances with 0, 2 and 3 wait states
// share the request bus; dsel picks which one sees req_valid and is observed.
module tb_data_memory_ws;
   logic        clk = 1'b0;
   logic        reset;
   logic        vld;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   int          dsel;
   int          n_cmp = 0;
   int          n_err = 0;

   logic        v0, v2, v3;
   logic        rdy0, rdy2, rdy3, rv0, rv2, rv3, er0, er2, er3, bz0, bz2, bz3;
   logic [31:0] rd0, rd2, rd3;
   logic        rdy_s, rv_s, er_s, bz_s;
   logic [31:0] rd_s;

   always #5 clk = ~clk;

   assign v0    = vld && (dsel == 0);
   assign v2    = vld && (dsel == 2);
   assign v3    = vld && (dsel == 3);
   assign rdy_s = (dsel == 0) ? rdy0 : (dsel == 3) ? rdy3 : rdy2;
   assign rv_s  = (dsel == 0) ? rv0  : (dsel == 3) ? rv3  : rv2;
   assign er_s  = (dsel == 0) ? er0  : (dsel == 3) ? er3  : er2;
   assign bz_s  = (dsel == 0) ? bz0  : (dsel == 3) ? bz3  : bz2;
   assign rd_s  = (dsel == 0) ? rd0  : (dsel == 3) ? rd3  : rd2;

   data_memory_ws #(.DEPTH_BYTES(128), .ADDR_W(32), .LATENCY(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0), .busy(bz0));
   data_memory_ws #(.DEPTH_BYTES(128), .ADDR_W(32), .LATENCY(2)) dut2 (
      .clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv2), .resp_rdata(rd2), .resp_err(er2), .busy(bz2));
   data_memory_ws #(.DEPTH_BYTES(128), .ADDR_W(32), .LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3), .busy(bz3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setreq(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
      req_write    = w;
      req_size     = sz;
      req_unsigned = u;
      req_addr     = a;
      req_wdata    = wd;
   endtask

   // One isolated access: response must appear exactly lat edges after the accept edge.
   task automatic txn(input string tag, input int lat, input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_er, input bit chk_rd);
      setreq(w, sz, u, a, wd);
      chk({tag, "_ready"}, {31'd0, rdy_s}, 32'd1);
      vld = 1'b1;
      step();
      vld = 1'b0;
      for (int j = 0; j < lat; j++) begin
         chk({tag, "_early_rv"}, {31'd0, rv_s}, 32'd0);
         chk({tag, "_busy"}, {31'd0, bz_s}, 32'd1);
         step();
      end
      chk({tag, "_rv"}, {31'd0, rv_s}, 32'd1);
      chk({tag, "_err"}, {31'd0, er_s}, {31'd0, exp_er});
      if (chk_rd) begin
         chk({tag, "_rdata"}, rd_s, exp_rd);
      end else begin
         chk({tag, "_nop_rv"}, {31'd0, rv_s}, 32'd1);
      end
      step();
      chk({tag, "_rv_drop"}, {31'd0, rv_s}, 32'd0);
      chk({tag, "_idle"}, {31'd0, bz_s}, 32'd0);
   endtask

   initial begin
      dsel  = 2;
      vld   = 1'b0;
      reset = 1'b0;
      setreq(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      step();
      step();
      for (int d = 0; d < 4; d++) begin
         if (d != 1) begin
            dsel = d;
            #1;
            chk("rst_rv",    {31'd0, rv_s},  32'd0);
            chk("rst_err",   {31'd0, er_s},  32'd0);
            chk("rst_busy",  {31'd0, bz_s},  32'd0);
            chk("rst_rdata", rd_s,           32'd0);
            chk("rst_ready", {31'd0, rdy_s}, 32'd0);
         end
      end
      reset = 1'b1;
      dsel  = 2;
      #1;
      chk("rel_ready", {31'd0, rdy_s}, 32'd1);

      // T1/T2: word store then word/byte/half loads, LATENCY=2
      txn("t1_st",   2, 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
      txn("t1_ld",   2, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      txn("t2_lbs",  2, 1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 32'hFFFFFFDE, 1'b0, 1'b1);
      txn("t2_lbu",  2, 1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 32'h000000DE, 1'b0, 1'b1);
      txn("t2_lhs",  2, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'hFFFFDEAD, 1'b0, 1'b1);
      txn("t2_lhu",  2, 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 32'h0000DEAD, 1'b0, 1'b1);

      // T3: errors leave memory untouched; half at the last legal address is fine
      txn("t3_top",  2, 1'b1, 2'b01, 1'b0, 32'h7E, 32'h0000BEEF, 32'h0, 1'b0, 1'b1);
      txn("t3_mish", 2, 1'b1, 2'b01, 1'b0, 32'h15, 32'h00001234, 32'h0, 1'b1, 1'b1);
      txn("t3_misw", 2, 1'b1, 2'b10, 1'b0, 32'h7E, 32'h99999999, 32'h0, 1'b1, 1'b1);
      txn("t3_wrap", 2, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1'b1);
      txn("t3_sz11", 2, 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 32'h0, 1'b1, 1'b1);
      txn("t3_rng",  2, 1'b1, 2'b10, 1'b0, 32'h80, 32'h77777777, 32'h0, 1'b1, 1'b1);
      txn("t3_kp7e", 2, 1'b0, 2'b01, 1'b1, 32'h7E, 32'h0, 32'h0000BEEF, 1'b0, 1'b1);
      txn("t3_kp14", 2, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      txn("t3_kp15", 2, 1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 32'hFFFFFFBE, 1'b0, 1'b1);

      // T6: a request held during WAIT is taken only from RESP
      setreq(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
      vld = 1'b1;
      step();
      setreq(1'b0, 2'b00, 1'b1, 32'h14, 32'h0);
      chk("t6_rdy_w1", {31'd0, rdy_s}, 32'd0);
      step();
      chk("t6_rdy_w2", {31'd0, rdy_s}, 32'd0);
      chk("t6_rv_w2",  {31'd0, rv_s},  32'd0);
      step();
      chk("t6_rv_a",   {31'd0, rv_s},  32'd1);
      chk("t6_rd_a",   rd_s,           32'hDEADBEEF);
      chk("t6_rdy_r",  {31'd0, rdy_s}, 32'd1);
      step();
      vld = 1'b0;
      chk("t6_rv_x",   {31'd0, rv_s},  32'd0);
      chk("t6_busy",   {31'd0, bz_s},  32'd1);
      step();
      chk("t6_rv_y",   {31'd0, rv_s},  32'd0);
      step();
      chk("t6_rv_b",   {31'd0, rv_s},  32'd1);
      chk("t6_rd_b",   rd_s,           32'h000000EF);
      step();
      chk("t6_idle",   {31'd0, bz_s},  32'd0);

      // T4: LATENCY=0, back-to-back accesses with req_valid held
      dsel = 0;
      setreq(1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344);
      vld = 1'b1;
      #1;
      chk("t4_rdy0", {31'd0, rdy_s}, 32'd1);
      step();
      chk("t4_rv1",  {31'd0, rv_s},  32'd1);
      chk("t4_rdy1", {31'd0, rdy_s}, 32'd1);
      setreq(1'b1, 2'b10, 1'b0, 32'h4, 32'h55667788);
      step();
      chk("t4_rv2",  {31'd0, rv_s},  32'd1);
      chk("t4_rdy2", {31'd0, rdy_s}, 32'd1);
      setreq(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      step();
      chk("t4_rv3",  {31'd0, rv_s},  32'd1);
      chk("t4_rd3",  rd_s,           32'h11223344);
      chk("t4_rdy3", {31'd0, rdy_s}, 32'd1);
      setreq(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
      step();
      chk("t4_rv4",  {31'd0, rv_s},  32'd1);
      chk("t4_rd4",  rd_s,           32'h55667788);
      vld = 1'b0;
      step();
      chk("t4_rv5",  {31'd0, rv_s},  32'd0);
      chk("t4_idle", {31'd0, bz_s},  32'd0);
      txn("t4_lbs",  0, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'hFFFFFF88, 1'b0, 1'b1);
      txn("t4_lhu",  0, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'h00001122, 1'b0, 1'b1);

      // T5: reset drops an uncommitted store, LATENCY=3
      dsel = 3;
      txn("t5_st0",  3, 1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, 32'h0, 1'b0, 1'b0);
      txn("t5_ld0",  3, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h01020304, 1'b0, 1'b1);
      setreq(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5);
      vld = 1'b1;
      step();
      vld   = 1'b0;
      reset = 1'b0;
      step();
      chk("t5_rv",    {31'd0, rv_s},  32'd0);
      chk("t5_rd",    rd_s,           32'd0);
      chk("t5_err",   {31'd0, er_s},  32'd0);
      chk("t5_busy",  {31'd0, bz_s},  32'd0);
      chk("t5_ready", {31'd0, rdy_s}, 32'd0);
      reset = 1'b1;
      step();
      step();
      step();
      chk("t5_quiet", {31'd0, rv_s},  32'd0);
      txn("t5_ld1",  3, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h01020304, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
